cpu_nios2_qsys_0_oci_dct_packer: RTL
====================================

CPU_NIOS2_QSYS_0_OCI_DCT_PACKER -- requirements
Module: cpu_nios2_qsys_0_oci_dct_packer

Interface
REQ-001 SHALL have parameter ATOM_W, default 2: width of one trace atom in bits.
REQ-002 SHALL have parameter FRAME_ATOMS, default 15: atoms per full frame; ATOM_W*FRAME_ATOMS SHALL equal 30.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port atom_valid, input, 1: upstream atom offered.
REQ-006 SHALL have port atom, input, ATOM_W: atom payload.
REQ-007 SHALL have port atom_ready, output, 1: packer accepts atom this cycle.
REQ-008 SHALL have port flush, input, 1: single-cycle request to emit a partial frame.
REQ-009 SHALL have port test_ending, input, 1: level; end-of-test drain request.
REQ-010 SHALL have port dct_buffer, output, 30: packed frame.
REQ-011 SHALL have port dct_count, output, 4: number of valid atoms in dct_buffer.
REQ-012 SHALL have port frame_valid, output, 1: frame offered downstream.
REQ-013 SHALL have port frame_ready, input, 1: downstream accepts frame.
REQ-014 SHALL have port test_has_ended, output, 1: drain complete, sticky.

Function
REQ-015 SHALL implement states FILL, HOLD, DONE; FILL after reset.
REQ-016 SHALL drive atom_ready = (state==FILL) && !test_ending, combinationally.
REQ-017 SHALL accept an atom on an edge with atom_valid && atom_ready: dct_buffer <= {dct_buffer[29-ATOM_W:0], atom}, dct_count <= dct_count+1; visible the cycle after acceptance.
REQ-018 SHALL keep the newest atom in bits [ATOM_W-1:0]; the oldest of n atoms SHALL occupy bits [ATOM_W*n-1 : ATOM_W*(n-1)]; unused upper bits SHALL be 0.
REQ-019 SHALL go FILL->HOLD on the edge where dct_count reaches FRAME_ATOMS (15).
REQ-020 SHALL go FILL->HOLD on an edge with flush=1 and post-edge count>0; flush with count 0 and no accept SHALL be ignored.
REQ-021 SHALL, on flush coinciding with an atom accept, include that atom in the frame before entering HOLD.
REQ-022 SHALL, in FILL with test_ending=1, go to HOLD if dct_count>0, else to DONE.
REQ-023 SHALL assert frame_valid exactly while in HOLD; dct_buffer and dct_count SHALL remain stable in HOLD.
REQ-024 SHALL, in HOLD on frame_ready=1, clear dct_buffer and dct_count to 0 and go to DONE if test_ending=1, else FILL.
REQ-025 SHALL ignore flush in HOLD and DONE.
REQ-026 SHALL assert test_has_ended=1 in DONE; DONE SHALL be left only by reset.
REQ-027 SHALL never drop or duplicate an atom; dct_count SHALL never exceed 15.

Reset
REQ-028 SHALL on reset=1 at an edge set state FILL, dct_buffer 0, dct_count 0, frame_valid 0, test_has_ended 0, regardless of state (including mid-frame in HOLD).
REQ-029 SHALL hold atom_ready at 0 in the cycle reset is asserted.

Structure
REQ-030 SHALL place the state enum, ATOM_W/FRAME_ATOMS defaults and the 30/4-bit width constants in package cpu_nios2_qsys_0_oci_dct_pkg.
REQ-031 SHALL be a single module with no sub-modules; the existing OCI test bench SHALL be the consumer of dct_buffer, dct_count, test_ending and test_has_ended in simulation.

Verification
REQ-032 SHALL cover full frame: 15 atoms 2'b01 back-to-back, frame_ready=1 -> frame_valid for 1 cycle, dct_buffer=30'h15555555, dct_count=15, then count 0.
REQ-033 SHALL cover partial flush: atoms 3,2,1 then flush -> dct_buffer=30'h39, dct_count=3, atom_ready=0 until frame_ready.
REQ-034 SHALL cover backpressure: full frame with frame_ready=0 for 10 cycles -> outputs stable, atom_valid stalls, no atom lost.
REQ-035 SHALL cover simultaneous flush and accept at count 4 -> frame with dct_count=5.
REQ-036 SHALL cover drain: test_ending at count 7 -> HOLD, frame accepted, test_has_ended=1 one cycle later; test_ending at count 0 -> test_has_ended=1 on next edge.
REQ-037 SHALL cover reset asserted in HOLD -> all outputs 0, state FILL next cycle.

Source files
------------

// File: rtl/cpu_nios2_qsys_0_oci_dct_pkg.sv
// Shared types and width constants for the OCI trace-atom packer.
package cpu_nios2_qsys_0_oci_dct_pkg;

    typedef enum logic [1:0] {
        ST_FILL = 2'd0,
        ST_HOLD = 2'd1,
        ST_DONE = 2'd2
    } dct_state_e;

    localparam int DCT_ATOM_W_DEF      = 2;
    localparam int DCT_FRAME_ATOMS_DEF = 15;
    localparam int DCT_BUF_W           = 30;
    localparam int DCT_CNT_W           = 4;

endpackage

// File: rtl/cpu_nios2_qsys_0_oci_dct_packer.sv
// Packs trace atoms into a 30-bit frame (newest atom in the LSBs) and hands the
// frame downstream with a valid/ready handshake; supports flush and end-of-test drain.
module cpu_nios2_qsys_0_oci_dct_packer
    import cpu_nios2_qsys_0_oci_dct_pkg::*;
#(
    parameter int ATOM_W      = DCT_ATOM_W_DEF,
    parameter int FRAME_ATOMS = DCT_FRAME_ATOMS_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 atom_valid,
    input  logic [ATOM_W-1:0]    atom,
    output logic                 atom_ready,
    input  logic                 flush,
    input  logic                 test_ending,
    output logic [DCT_BUF_W-1:0] dct_buffer,
    output logic [DCT_CNT_W-1:0] dct_count,
    output logic                 frame_valid,
    input  logic                 frame_ready,
    output logic                 test_has_ended
);

    localparam logic [DCT_CNT_W-1:0] FULL_CNT = DCT_CNT_W'(FRAME_ATOMS);

    dct_state_e              r_state;
    logic [DCT_BUF_W-1:0]    r_buf;
    logic [DCT_CNT_W-1:0]    r_cnt;

    dct_state_e              w_state_nxt;
    logic [DCT_BUF_W-1:0]    w_buf_nxt;
    logic [DCT_CNT_W-1:0]    w_cnt_nxt;
    logic [DCT_CNT_W-1:0]    w_cnt_acc;
    logic                    w_accept;

    // Reset gates atom_ready so nothing is accepted on the reset edge.
    assign atom_ready = (r_state == ST_FILL) && !test_ending && !reset;
    assign w_accept   = atom_valid && atom_ready;
    assign w_cnt_acc  = r_cnt + DCT_CNT_W'(w_accept);

    assign dct_buffer     = r_buf;
    assign dct_count      = r_cnt;
    assign frame_valid    = (r_state == ST_HOLD);
    assign test_has_ended = (r_state == ST_DONE);

    always_comb begin
        w_state_nxt = r_state;
        w_buf_nxt   = r_buf;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            ST_FILL: begin
                if (w_accept) begin
                    w_buf_nxt = {r_buf[DCT_BUF_W-ATOM_W-1:0], atom};
                    w_cnt_nxt = w_cnt_acc;
                end
                // A flush on the accepting edge still closes the frame with that atom in it.
                if (w_cnt_acc == FULL_CNT) begin
                    w_state_nxt = ST_HOLD;
                end else if (flush && (w_cnt_acc != '0)) begin
                    w_state_nxt = ST_HOLD;
                end else if (test_ending) begin
                    w_state_nxt = (r_cnt != '0) ? ST_HOLD : ST_DONE;
                end
            end
            ST_HOLD: begin
                if (frame_ready) begin
                    w_buf_nxt   = '0;
                    w_cnt_nxt   = '0;
                    w_state_nxt = test_ending ? ST_DONE : ST_FILL;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_DONE;
            end
            default: begin
                w_state_nxt = ST_FILL;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_FILL;
            r_buf   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_buf   <= w_buf_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

endmodule
